// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS32 pipeline hazard logic.
package mips_pipe_pkg;

  localparam int unsigned REG_AW = 5;

  // sll $0,$0,0
  localparam logic [31:0] NopInstr = 32'h0000_0000;

  // Shadow copy of one in-flight instruction past ID
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] waddr;
    logic              reg_wr;
    logic              is_load;
  } shadow_entry_t;

  localparam shadow_entry_t EntryInvalid = '{valid: 1'b0, waddr: '0, reg_wr: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side handshake between the ID stage and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned REG_AW = 5
);
  localparam int unsigned SelW = $clog2(STAGES + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_raddr1;
  logic [REG_AW-1:0] id_raddr2;
  logic              id_use1;
  logic              id_use2;
  logic [REG_AW-1:0] id_waddr;
  logic              id_reg_wr;
  logic              id_is_load;
  logic              id_is_mdu;
  logic              ex_redirect;

  logic              stall;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              ex_hold;
  logic              mdu_busy;
  logic [SelW-1:0]   fwd_sel1;
  logic [SelW-1:0]   fwd_sel2;

  // Decode / pipeline side
  modport master (
    output id_valid, id_raddr1, id_raddr2, id_use1, id_use2, id_waddr,
           id_reg_wr, id_is_load, id_is_mdu, ex_redirect,
    input  stall, if_id_flush, id_ex_bubble, ex_hold, mdu_busy, fwd_sel1, fwd_sel2
  );

  // Hazard controller side
  modport slave (
    input  id_valid, id_raddr1, id_raddr2, id_use1, id_use2, id_waddr,
           id_reg_wr, id_is_load, id_is_mdu, ex_redirect,
    output stall, if_id_flush, id_ex_bubble, ex_hold, mdu_busy, fwd_sel1, fwd_sel2
  );

endinterface

// File: rtl/fwd_match.sv
// Priority RAW match of one source operand against the shadow array.
module fwd_match
  import mips_pipe_pkg::*;
#(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_STAGE = 2
) (
  input  shadow_entry_t [STAGES:1]             shadow_i,
  input  logic [REG_AW-1:0]                    raddr_i,
  input  logic                                 use_i,
  output logic                                 hit_o,
  output logic [$clog2(STAGES + 1)-1:0]        sel_o,
  output logic                                 load_block_o
);
  localparam int unsigned SelW = $clog2(STAGES + 1);

  // Scan oldest to youngest so the smallest matching k is the last writer
  always_comb begin
    hit_o        = 1'b0;
    sel_o        = '0;
    load_block_o = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (shadow_i[k].valid && shadow_i[k].reg_wr && use_i && (raddr_i != '0) &&
          (shadow_i[k].waddr == raddr_i)) begin
        hit_o        = 1'b1;
        sel_o        = SelW'(k);
        // load data is not yet available below LOAD_STAGE
        load_block_o = shadow_i[k].is_load && (k < int'(LOAD_STAGE));
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the in-order MIPS32 pipeline.
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned REG_AW     = mips_pipe_pkg::REG_AW,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned MDU_LAT    = 4,
  parameter bit          FWD_EN     = 1'b1
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  import mips_pipe_pkg::*;

  localparam int unsigned SelW = $clog2(STAGES + 1);
  localparam int unsigned CntW = $clog2(MDU_LAT + 1);

  shadow_entry_t [STAGES:1] shadow_q, shadow_d;
  logic [CntW-1:0]          mdu_cnt_q, mdu_cnt_d;
  logic [SelW-1:0]          sel1_q, sel1_d, sel2_q, sel2_d;

  logic              hit1, hit2, lb1, lb2;
  logic [SelW-1:0]   msel1, msel2;
  logic              hold, raw_stall, flush, stall, issue;
  logic [REG_AW-1:0] id_waddr;

  assign id_waddr = bus.id_waddr;

  fwd_match #(.STAGES(STAGES), .LOAD_STAGE(LOAD_STAGE)) u_match1 (
    .shadow_i     (shadow_q),
    .raddr_i      (bus.id_raddr1),
    .use_i        (bus.id_use1),
    .hit_o        (hit1),
    .sel_o        (msel1),
    .load_block_o (lb1)
  );

  fwd_match #(.STAGES(STAGES), .LOAD_STAGE(LOAD_STAGE)) u_match2 (
    .shadow_i     (shadow_q),
    .raddr_i      (bus.id_raddr2),
    .use_i        (bus.id_use2),
    .hit_o        (hit2),
    .sel_o        (msel2),
    .load_block_o (lb2)
  );

  // Stall/flush decode; a redirect is ignored while EX is held
  always_comb begin
    hold      = (mdu_cnt_q != '0);
    raw_stall = FWD_EN ? (lb1 | lb2) : (hit1 | hit2);
    flush     = bus.ex_redirect & ~hold;
    stall     = ~flush & bus.id_valid & (raw_stall | hold);
    issue     = bus.id_valid & ~stall & ~flush;
  end

  assign bus.stall        = stall;
  assign bus.if_id_flush  = flush;
  assign bus.id_ex_bubble = flush | (stall & ~hold);
  assign bus.ex_hold      = hold;
  assign bus.mdu_busy     = hold;
  assign bus.fwd_sel1     = sel1_q;
  assign bus.fwd_sel2     = sel2_q;

  // Next state: shadow shift, MDU countdown and forwarding selects for the next EX
  always_comb begin
    shadow_d  = shadow_q;
    mdu_cnt_d = mdu_cnt_q;
    sel1_d    = '0;
    sel2_d    = '0;

    // stages past MEM always drain, even during an MDU hold
    for (int k = STAGES; k >= 3; k--) begin
      shadow_d[k] = shadow_q[k-1];
    end
    if (hold) begin
      shadow_d[2] = EntryInvalid;
    end else begin
      shadow_d[2] = shadow_q[1];
      if (issue) begin
        shadow_d[1] = '{valid: 1'b1, waddr: id_waddr, reg_wr: bus.id_reg_wr,
                        is_load: bus.id_is_load};
      end else begin
        shadow_d[1] = EntryInvalid;
      end
    end

    if (issue && bus.id_is_mdu) begin
      mdu_cnt_d = CntW'(MDU_LAT - 1);
    end else if (hold) begin
      mdu_cnt_d = mdu_cnt_q - CntW'(1);
    end

    // selects refer to pre-shift positions: producer at k is source k
    if (issue) begin
      sel1_d = FWD_EN ? msel1 : '0;
      sel2_d = FWD_EN ? msel2 : '0;
    end else if (hold) begin
      sel1_d = sel1_q;
      sel2_d = sel2_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      mdu_cnt_q <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
    end else begin
      shadow_q  <= shadow_d;
      mdu_cnt_q <= mdu_cnt_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, two DUTs (forwarding on/off).
module tb_pipe_hazard_ctrl;
  localparam int S   = 3;
  localparam int LS  = 2;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic in_rst;
  logic in_idv, in_u1, in_u2, in_wr, in_ld, in_mdu, in_redir;
  logic [4:0] in_r1, in_r2, in_wa;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.STAGES(S), .REG_AW(5)) ifa ();
  pipe_hazard_ctrl_if #(.STAGES(S), .REG_AW(5)) ifb ();

  assign ifa.id_valid = in_idv;    assign ifb.id_valid = in_idv;
  assign ifa.id_raddr1 = in_r1;    assign ifb.id_raddr1 = in_r1;
  assign ifa.id_raddr2 = in_r2;    assign ifb.id_raddr2 = in_r2;
  assign ifa.id_use1 = in_u1;      assign ifb.id_use1 = in_u1;
  assign ifa.id_use2 = in_u2;      assign ifb.id_use2 = in_u2;
  assign ifa.id_waddr = in_wa;     assign ifb.id_waddr = in_wa;
  assign ifa.id_reg_wr = in_wr;    assign ifb.id_reg_wr = in_wr;
  assign ifa.id_is_load = in_ld;   assign ifb.id_is_load = in_ld;
  assign ifa.id_is_mdu = in_mdu;   assign ifb.id_is_mdu = in_mdu;
  assign ifa.ex_redirect = in_redir; assign ifb.ex_redirect = in_redir;

  pipe_hazard_ctrl #(.STAGES(S), .REG_AW(5), .LOAD_STAGE(LS), .MDU_LAT(LAT), .FWD_EN(1'b1))
    u_dut_fwd (.clk(clk), .rst(in_rst), .bus(ifa));
  pipe_hazard_ctrl #(.STAGES(S), .REG_AW(5), .LOAD_STAGE(LS), .MDU_LAT(LAT), .FWD_EN(1'b0))
    u_dut_nofwd (.clk(clk), .rst(in_rst), .bus(ifb));

  // Reference model: list of in-flight register writers with their current stage number
  typedef struct {
    int         v;
    int         stage;
    logic [4:0] wa;
    bit         ld;
  } inflight_t;

  inflight_t fl[$];
  int fwd_on[2] = '{1, 0};
  int rem[2];
  int selq1[2], selq2[2], nsel1[2], nsel2[2];
  bit e_stall[2], e_flush[2], e_bub[2], e_issue[2], e_hold[2];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int youngest(input int v, input logic [4:0] ra, input logic use_b);
    int idx = -1;
    if (use_b && ra != 5'd0) begin
      foreach (fl[i]) begin
        if (fl[i].v == v && fl[i].wa == ra && (idx < 0 || fl[i].stage < fl[idx].stage)) idx = i;
      end
    end
    return idx;
  endfunction

  task automatic model_eval(input int v);
    int  i1, i2;
    bit  raw1, raw2, hold;
    i1   = youngest(v, in_r1, in_u1);
    i2   = youngest(v, in_r2, in_u2);
    raw1 = (i1 >= 0) && (fwd_on[v] == 0 || (fl[i1].ld && fl[i1].stage < LS));
    raw2 = (i2 >= 0) && (fwd_on[v] == 0 || (fl[i2].ld && fl[i2].stage < LS));
    hold = rem[v] > 0;
    e_hold[v]  = hold;
    e_flush[v] = in_redir && !hold;
    e_stall[v] = !e_flush[v] && in_idv && (raw1 || raw2 || hold);
    e_bub[v]   = e_flush[v] || (e_stall[v] && !hold);
    e_issue[v] = in_idv && !e_stall[v] && !e_flush[v];
    if (e_issue[v]) begin
      nsel1[v] = (fwd_on[v] != 0 && i1 >= 0) ? fl[i1].stage : 0;
      nsel2[v] = (fwd_on[v] != 0 && i2 >= 0) ? fl[i2].stage : 0;
    end else if (hold) begin
      nsel1[v] = selq1[v];
      nsel2[v] = selq2[v];
    end else begin
      nsel1[v] = 0;
      nsel2[v] = 0;
    end
  endtask

  task automatic model_update(input int v);
    inflight_t e;
    for (int i = fl.size() - 1; i >= 0; i--) begin
      if (fl[i].v == v) begin
        e = fl[i];
        if (in_rst) begin
          fl.delete(i);
        end else begin
          if (!(e_hold[v] && e.stage == 1)) e.stage = e.stage + 1;
          if (e.stage > S) fl.delete(i);
          else fl[i] = e;
        end
      end
    end
    if (in_rst) begin
      rem[v] = 0; selq1[v] = 0; selq2[v] = 0;
    end else begin
      if (e_issue[v] && in_wr) begin
        e.v = v; e.stage = 1; e.wa = in_wa; e.ld = in_ld;
        fl.push_back(e);
      end
      if (e_issue[v] && in_mdu) rem[v] = LAT - 1;
      else if (rem[v] > 0) rem[v] = rem[v] - 1;
      selq1[v] = nsel1[v];
      selq2[v] = nsel2[v];
    end
  endtask

  task automatic compare(input int v);
    string sfx;
    logic o_stall, o_flush, o_bub, o_hold, o_busy;
    logic [1:0] o_s1, o_s2;
    sfx = (v == 0) ? "_fwd" : "_nofwd";
    if (v == 0) begin
      o_stall = ifa.stall; o_flush = ifa.if_id_flush; o_bub = ifa.id_ex_bubble;
      o_hold = ifa.ex_hold; o_busy = ifa.mdu_busy; o_s1 = ifa.fwd_sel1; o_s2 = ifa.fwd_sel2;
    end else begin
      o_stall = ifb.stall; o_flush = ifb.if_id_flush; o_bub = ifb.id_ex_bubble;
      o_hold = ifb.ex_hold; o_busy = ifb.mdu_busy; o_s1 = ifb.fwd_sel1; o_s2 = ifb.fwd_sel2;
    end
    chk({"stall", sfx}, 32'(o_stall), 32'(e_stall[v]));
    chk({"flush", sfx}, 32'(o_flush), 32'(e_flush[v]));
    chk({"bubble", sfx}, 32'(o_bub), 32'(e_bub[v]));
    chk({"ex_hold", sfx}, 32'(o_hold), 32'(e_hold[v]));
    chk({"mdu_busy", sfx}, 32'(o_busy), 32'(e_hold[v]));
    chk({"fwd_sel1", sfx}, 32'(o_s1), 32'(selq1[v]));
    chk({"fwd_sel2", sfx}, 32'(o_s2), 32'(selq2[v]));
  endtask

  // One clock: check both DUTs against the model, cross the edge, advance the model
  task automatic step();
    for (int v = 0; v < 2; v++) begin
      model_eval(v);
      compare(v);
    end
    @(posedge clk);
    for (int v = 0; v < 2; v++) model_update(v);
    @(negedge clk);
  endtask

  task automatic drive(input logic idv, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] wa,
                       input logic wr, input logic ld, input logic mdu, input logic redir);
    in_idv = idv; in_r1 = r1; in_u1 = u1; in_r2 = r2; in_u2 = u2;
    in_wa = wa; in_wr = wr; in_ld = ld; in_mdu = mdu; in_redir = redir;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    in_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    // reset state, cycle after rst is sampled
    chk("rst_stall", 32'(ifa.stall), 0);
    chk("rst_bubble", 32'(ifa.id_ex_bubble), 0);
    chk("rst_hold", 32'(ifa.ex_hold), 0);
    chk("rst_sel1", 32'(ifa.fwd_sel1), 0);
    chk("rst_sel2_nofwd", 32'(ifb.fwd_sel2), 0);
    step();
    in_rst = 1'b0;
    idle(2);

    // add $3 then sub $4,$3,$1
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0);
    step();
    drive(1, 5'd3, 1, 5'd1, 1, 5'd4, 1, 0, 0, 0);
    chk("addsub_nostall", 32'(ifa.stall), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("addsub_sel1", 32'(ifa.fwd_sel1), 1);
    step();
    idle(4);

    // lw $5 then add $6,$5,$5
    drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0);
    step();
    drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0);
    chk("lu_stall", 32'(ifa.stall), 1);
    chk("lu_bubble", 32'(ifa.id_ex_bubble), 1);
    step();
    chk("lu_release", 32'(ifa.stall), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_sel1", 32'(ifa.fwd_sel1), 2);
    chk("lu_sel2", 32'(ifa.fwd_sel2), 2);
    step();
    idle(4);

    // writer of $0 then reader of $0
    drive(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0);
    step();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 0, 0);
    chk("r0_stall_fwd", 32'(ifa.stall), 0);
    chk("r0_stall_nofwd", 32'(ifb.stall), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_sel1", 32'(ifa.fwd_sel1), 0);
    step();
    idle(4);

    // forwarding off: add $3 then reader of $3 costs STAGES cycles
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0);
    step();
    drive(1, 5'd3, 1, 5'd0, 0, 5'd10, 1, 0, 0, 0);
    for (int i = 0; i < S; i++) begin
      chk("nofwd_stall", 32'(ifb.stall), 1);
      step();
    end
    chk("nofwd_release", 32'(ifb.stall), 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("nofwd_sel1", 32'(ifb.fwd_sel1), 0);
    step();
    idle(4);

    // mult then independent add
    drive(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1, 0);
    step();
    drive(1, 5'd1, 1, 5'd2, 1, 5'd8, 1, 0, 0, 0);
    for (int i = 0; i < LAT - 1; i++) begin
      chk("mdu_hold", 32'(ifa.ex_hold), 1);
      chk("mdu_busy", 32'(ifa.mdu_busy), 1);
      chk("mdu_stall", 32'(ifa.stall), 1);
      step();
    end
    chk("mdu_done", 32'(ifa.ex_hold), 0);
    chk("mdu_issue", 32'(ifa.stall), 0);
    step();
    idle(4);

    // redirect during a load-use stall
    drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0);
    step();
    drive(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 1);
    chk("redir_flush", 32'(ifa.if_id_flush), 1);
    chk("redir_stall", 32'(ifa.stall), 0);
    chk("redir_bubble", 32'(ifa.id_ex_bubble), 1);
    chk("redir_flush_nofwd", 32'(ifb.if_id_flush), 1);
    step();
    drive(1, 5'd6, 1, 5'd0, 0, 5'd11, 1, 0, 0, 0);
    chk("redir_e1_empty", 32'(ifb.stall), 0);
    step();
    idle(4);

    // reset during MDU hold with a pending RAW
    drive(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1, 0);
    step();
    drive(1, 5'd9, 1, 5'd0, 0, 5'd12, 1, 0, 0, 0);
    chk("prerst_hold", 32'(ifa.ex_hold), 1);
    step();
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    chk("postrst_stall", 32'(ifa.stall), 0);
    chk("postrst_hold", 32'(ifa.ex_hold), 0);
    chk("postrst_busy", 32'(ifa.mdu_busy), 0);
    chk("postrst_bubble", 32'(ifa.id_ex_bubble), 0);
    chk("postrst_sel1", 32'(ifa.fwd_sel1), 0);
    chk("postrst_stall_nofwd", 32'(ifb.stall), 0);
    step();
    idle(4);

    // random traffic over a small register set to provoke many matches
    for (int c = 0; c < 800; c++) begin
      in_rst = ($urandom_range(0, 63) == 0);
      drive(1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
            1'((rem[0] == 0) && (rem[1] == 0) && ($urandom_range(0, 9) == 0)));
      step();
    end
    in_rst = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the in-order MIPS32 pipeline. It tracks a shadow copy of every in-flight instruction past ID and issues stall, bubble and flush controls. It generates registered forwarding selects for both EX operands and holds EX for multi-cycle multiply/divide ops. It sits beside the decode stage and drives the enables of the pc, if_id and id_ex registers.

## Interface

- STAGES, 3, post-ID stages tracked (1=EX, 2=MEM, 3=WB); legal 2..6
- REG_AW, 5, register address width
- LOAD_STAGE, 2, lowest forwarding source index at which load data exists; legal 2..STAGES
- MDU_LAT, 4, EX occupancy in cycles of an MDU op; legal 1..32
- FWD_EN, 1, 1 = forwarding on; 0 = stall on every RAW match
- clk  in  1  clock; one clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_raddr1, id_raddr2  in  REG_AW  source registers
- id_use1, id_use2  in  1  source actually read
- id_waddr  in  REG_AW  destination register
- id_reg_wr  in  1  writes register file
- id_is_load  in  1  load instruction
- id_is_mdu  in  1  multi-cycle MDU instruction
- ex_redirect  in  1  branch/jump resolved taken in EX
- stall  out  1  hold pc and if_id
- if_id_flush  out  1  clear if_id to NOP
- id_ex_bubble  out  1  load NOP into id_ex
- ex_hold  out  1  hold id_ex/EX, bubble into EX→MEM
- mdu_busy  out  1  MDU counter non-zero
- fwd_sel1, fwd_sel2  out  $clog2(STAGES+1)  0 = regfile, k = result register at output of stage k

## Operation

- Shadow entry k (1..STAGES) holds valid, waddr, reg_wr and is_load for the instruction in stage k.
- A match at k requires: entry valid, reg_wr set, waddr == raddr, raddr != 0, use bit set.
- Per operand, the smallest k with a match wins; this is the youngest producer.
- FWD_EN=1, winner not a load: sel = k, no stall.
- FWD_EN=1, winner is a load at k < LOAD_STAGE: raise load-use stall. A load at k ≥ LOAD_STAGE forwards with sel = k.
- FWD_EN=0: any match raises stall; sel is always 0.
- stall = id_valid & (RAW stall | ex_hold). When stall is high and ex_hold is low, id_ex_bubble = 1.
- ex_redirect (only honoured while ex_hold = 0): if_id_flush = 1, id_ex_bubble = 1, stall = 0. Flush has priority over RAW stall.
- MDU counter:
  - Loads MDU_LAT-1 when an MDU op enters stage 1.
  - Decrements each cycle while non-zero.
  - ex_hold = mdu_busy. While ex_hold is high, entry 1 is frozen and entry 2 receives invalid.
- Shadow advance when not holding: entry k+1 ← entry k; entry 1 ← ID fields if ID issues, else invalid. Entries beyond STAGES are dropped.

## Timing

- stall, if_id_flush, id_ex_bubble and ex_hold are combinational from the ID inputs and registered state, within the same cycle.
- fwd_sel1/2 are registered on the edge that moves the instruction ID→EX, so they are valid during that instruction's EX cycle.
- They are computed against the shadow state before the shift: producer at k becomes source k.
- fwd_sel holds its value while ex_hold = 1. It is 0 when a bubble enters EX.
- Load-use with the default parameters costs exactly 1 stall cycle. With FWD_EN=0, a dependency on stage 1 costs STAGES cycles.
- An MDU op occupies EX for MDU_LAT cycles. A dependent op immediately behind it stalls MDU_LAT-1 cycles for the hold, plus any RAW stall.
- An ex_redirect asserted while ex_hold = 1 is ignored; the bench asserts it never occurs.
- Reset state:
  - All shadow entries invalid, counter 0, fwd_sel 0.
  - All outputs 0 in the cycle after rst is sampled.
  - Reset mid-MDU or mid-stall aborts immediately.

## Structure

- Package mips_pipe_pkg holds REG_AW, the NOP encoding and a shadow_entry_t struct (valid, waddr, reg_wr, is_load).
- Sub-module fwd_match, instantiated twice (one per operand), does the priority match over the shadow array. It outputs hit, sel and load_block.

## Test plan

- add $3 then sub $4,$3,$1 back-to-back (defaults) → no stall, fwd_sel1 = 1 in sub's EX cycle.
- lw $5 then add $6,$5,$5 → stall = 1 and id_ex_bubble = 1 for exactly 1 cycle, then fwd_sel1 = fwd_sel2 = 2.
- Writes to $0 followed by a reader of $0 → no stall, sel 0. With FWD_EN=0, add $3 then reader of $3 → stall 3 cycles, sel 0.
- mult (MDU_LAT=4) then independent add → ex_hold high 3 cycles, mdu_busy 3,2,1, add enters EX on cycle 4.
- ex_redirect in the same cycle as a load-use stall → if_id_flush = 1, stall = 0, bubble into EX, shadow entry 1 invalid next cycle.
- rst asserted during MDU hold with a pending RAW → next cycle all outputs 0, counter 0, shadow empty.
